hline_move_ctrl: RTL and testbench

HLINE_MOVE_CTRL -- requirements
Module: hline_move_ctrl

---
 rtl/hline_move_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hline_move_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hline_move_ctrl.sv
// Bouncing horizontal-line motion controller: drives UP/DW/LD strobes of an
// external line counter and reverses direction at the Y_MIN/Y_MAX limits.
module hline_move_ctrl #(
    parameter logic [15:0] Y_MIN = 16'd18,
    parameter logic [15:0] Y_MAX = 16'd630
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame,
    input  logic        go,
    input  logic        halt,
    input  logic        freeze,
    input  logic [1:0]  speed,
    input  logic [15:0] start_y,
    input  logic        at_max,
    input  logic        at_min,
    output logic        UP,
    output logic        DW,
    output logic        LD,
    output logic [15:0] load_y,
    output logic        dir,
    output logic        moving,
    output logic [7:0]  bounces
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_MOVE_INC = 2'd2,
        S_MOVE_DEC = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        up_q, up_d;
    logic        dw_q, dw_d;
    logic        ld_q, ld_d;
    logic [15:0] load_y_q, load_y_d;
    logic        dir_q, dir_d;
    logic        moving_q, moving_d;
    logic [7:0]  bounces_q, bounces_d;
    logic [1:0]  div_q, div_d;
    logic        start_s;
    logic        step_s;

    function automatic logic [15:0] clamp_y(input logic [15:0] y);
        logic [15:0] r;
        if (y < Y_MIN) begin
            r = Y_MIN;
        end else if (y > Y_MAX) begin
            r = Y_MAX;
        end else begin
            r = y;
        end
        return r;
    endfunction

    // Next-state and next-output computation; halt > go > freeze > frame.
    always_comb begin
        state_d   = state_q;
        up_d      = 1'b0;
        dw_d      = 1'b0;
        ld_d      = 1'b0;
        load_y_d  = load_y_q;
        dir_d     = dir_q;
        bounces_d = bounces_q;
        div_d     = div_q;
        start_s   = 1'b0;
        step_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (go) begin
                    start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (go) begin
                    start_s = 1'b1;
                end else begin
                    state_d = S_MOVE_INC;
                end
            end
            S_MOVE_INC, S_MOVE_DEC: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else if (go) begin
                    start_s = 1'b1;
                end else if (freeze) begin
                    div_d = div_q;
                end else if (frame) begin
                    if (div_q == speed) begin
                        div_d  = 2'd0;
                        step_s = 1'b1;
                    end else begin
                        div_d = div_q + 2'd1;
                    end
                end else begin
                    div_d = div_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_s) begin
            state_d  = S_LOAD;
            ld_d     = 1'b1;
            load_y_d = clamp_y(start_y);
            div_d    = 2'd0;
            dir_d    = 1'b1;
        end else begin
            ld_d = 1'b0;
        end

        // At a limit the step itself reverses, so the counter never overshoots.
        if (step_s && state_q == S_MOVE_INC) begin
            if (at_max) begin
                dw_d      = 1'b1;
                state_d   = S_MOVE_DEC;
                dir_d     = 1'b0;
                bounces_d = bounces_q + 8'd1;
            end else begin
                up_d = 1'b1;
            end
        end else if (step_s && state_q == S_MOVE_DEC) begin
            if (at_min) begin
                up_d      = 1'b1;
                state_d   = S_MOVE_INC;
                dir_d     = 1'b1;
                bounces_d = bounces_q + 8'd1;
            end else begin
                dw_d = 1'b1;
            end
        end else begin
            up_d = 1'b0;
            dw_d = 1'b0;
        end

        moving_d = (state_d == S_MOVE_INC) || (state_d == S_MOVE_DEC);
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            up_q      <= 1'b0;
            dw_q      <= 1'b0;
            ld_q      <= 1'b0;
            load_y_q  <= 16'd0;
            dir_q     <= 1'b1;
            moving_q  <= 1'b0;
            bounces_q <= 8'd0;
            div_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            up_q      <= up_d;
            dw_q      <= dw_d;
            ld_q      <= ld_d;
            load_y_q  <= load_y_d;
            dir_q     <= dir_d;
            moving_q  <= moving_d;
            bounces_q <= bounces_d;
            div_q     <= div_d;
        end
    end

    assign UP      = up_q;
    assign DW      = dw_q;
    assign LD      = ld_q;
    assign load_y  = load_y_q;
    assign dir     = dir_q;
    assign moving  = moving_q;
    assign bounces = bounces_q;

endmodule

// File: tb/tb_hline_move_ctrl.sv
// Directed self-checking bench for hline_move_ctrl.
module tb_hline_move_ctrl;

    logic        clk;
    logic        reset;
    logic        frame;
    logic        go;
    logic        halt;
    logic        freeze;
    logic [1:0]  speed;
    logic [15:0] start_y;
    logic        at_max;
    logic        at_min;
    logic        UP;
    logic        DW;
    logic        LD;
    logic [15:0] load_y;
    logic        dir;
    logic        moving;
    logic [7:0]  bounces;

    int n_checks = 0;
    int n_fail   = 0;

    hline_move_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .frame   (frame),
        .go      (go),
        .halt    (halt),
        .freeze  (freeze),
        .speed   (speed),
        .start_y (start_y),
        .at_max  (at_max),
        .at_min  (at_min),
        .UP      (UP),
        .DW      (DW),
        .LD      (LD),
        .load_y  (load_y),
        .dir     (dir),
        .moving  (moving),
        .bounces (bounces)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        frame   = 1'b0;
        go      = 1'b0;
        halt    = 1'b0;
        freeze  = 1'b0;
        speed   = 2'd0;
        start_y = 16'd0;
        at_max  = 1'b0;
        at_min  = 1'b0;
        #3;
        check_val("rst_up", UP, 0);
        check_val("rst_ld", LD, 0);
        check_val("rst_load_y", load_y, 0);
        check_val("rst_dir", dir, 1);
        check_val("rst_moving", moving, 0);
        check_val("rst_bounces", bounces, 0);
        tick();
        reset = 1'b0;

        // Stays idle without go, frames ignored
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
        check_val("idle_up", UP, 0);
        check_val("idle_moving", moving, 0);

        // V1
        start_y = 16'd100;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("v1_ld", LD, 1);
        check_val("v1_load_y", load_y, 100);
        tick();
        check_val("v1_ld_off", LD, 0);
        check_val("v1_moving", moving, 1);
        for (int i = 0; i < 5; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            check_val($sformatf("v1_up%0d", i), UP, 1);
            tick();
            check_val($sformatf("v1_up_off%0d", i), UP, 0);
        end

        // V2
        start_y = 16'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("v2_ld_lo", LD, 1);
        check_val("v2_clamp_lo", load_y, 18);
        tick();
        start_y = 16'd900;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val("v2_ld_hi", LD, 1);
        check_val("v2_clamp_hi", load_y, 630);
        tick();
        start_y = 16'd50;
        tick();
        check_val("v2_hold", load_y, 630);

        // V3
        at_max = 1'b1;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        at_max = 1'b0;
        check_val("v3_dw", DW, 1);
        check_val("v3_up0", UP, 0);
        check_val("v3_dir0", dir, 0);
        check_val("v3_b1", bounces, 1);
        tick();
        check_val("v3_dw_off", DW, 0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v3_dec_dw", DW, 1);
        tick();
        at_min = 1'b1;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        at_min = 1'b0;
        check_val("v3_up", UP, 1);
        check_val("v3_dw0", DW, 0);
        check_val("v3_dir1", dir, 1);
        check_val("v3_b2", bounces, 2);
        tick();

        // V4
        speed = 2'd2;
        for (int i = 1; i <= 9; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            check_val($sformatf("v4_f%0d", i), UP, (i % 3 == 0) ? 1 : 0);
            tick();
        end
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            check_val($sformatf("v4_frz_up%0d", i), UP, 0);
            check_val($sformatf("v4_frz_dw%0d", i), DW, 0);
            tick();
        end
        freeze = 1'b0;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v4_after2", UP, 0);
        tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v4_after3", UP, 1);
        tick();

        // V5
        speed = 2'd0;
        frame = 1'b1;
        halt = 1'b1;
        tick();
        frame = 1'b0;
        halt = 1'b0;
        check_val("v5_halt_up", UP, 0);
        check_val("v5_halt_dw", DW, 0);
        check_val("v5_halt_moving", moving, 0);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v5_idle_up", UP, 0);
        start_y = 16'd200;
        go = 1'b1;
        freeze = 1'b1;
        tick();
        go = 1'b0;
        freeze = 1'b0;
        check_val("v5_go_frz_ld", LD, 1);
        check_val("v5_load_y", load_y, 200);
        tick();
        check_val("v5_moving", moving, 1);
        check_val("v5_bounces_kept", bounces, 2);

        // V6
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v6_up", UP, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("v6_up_async", UP, 0);
        check_val("v6_moving", moving, 0);
        check_val("v6_bounces", bounces, 0);
        check_val("v6_load_y", load_y, 0);
        check_val("v6_dir", dir, 1);
        tick();
        reset = 1'b0;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check_val("v6_post_idle_up", UP, 0);
        check_val("v6_post_idle_mov", moving, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
